// File: rtl/mac_tx_arb.sv
// Frame-level two-source arbiter in front of a MAC transmit port.
// A source wins the port with a start-of-frame word and keeps it until its
// end-of-frame word is accepted or the frame stalls for too long. Words that
// arrive without a start-of-frame marker while the port is idle are drained
// and counted as strays.
module mac_tx_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s0_valid,
  input  logic                  s0_sof,
  input  logic                  s0_eof,
  output logic                  s0_ready,

  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  s1_valid,
  input  logic                  s1_sof,
  input  logic                  s1_eof,
  output logic                  s1_ready,

  output logic [DATA_WIDTH-1:0] mac_tx_data,
  output logic                  mac_tx_valid,
  output logic                  mac_tx_sof,
  output logic                  mac_tx_eof,
  input  logic                  mac_tx_ready,

  output logic                  err_timeout,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           frame_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  // The stall counter runs from 0 after the last handshake or grant; the
  // abort fires on the stall cycle that would take it to TIMEOUT-1, so the
  // pulse (registered) lands TIMEOUT cycles after the last handshake.
  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 2);

  state_t                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic [15:0]            stall_q, stall_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   err_timeout_q, err_timeout_d;

  logic                   sel_src;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   sel_valid;
  logic                   sel_sof;
  logic                   sel_eof;

  logic                   stray0;
  logic                   stray1;
  logic                   req0;
  logic                   req1;
  logic [16:0]            drop_sum;

  logic                   s0_ready_c;
  logic                   s1_ready_c;

  // Pick the view of whichever source currently owns the port
  always_comb begin
    sel_src   = (state_q == BUSY1);
    sel_data  = sel_src ? s1_data  : s0_data;
    sel_valid = sel_src ? s1_valid : s0_valid;
    sel_sof   = sel_src ? s1_sof   : s0_sof;
    sel_eof   = sel_src ? s1_eof   : s0_eof;
  end

  // Classify idle-time words into frame requests and strays, and form the
  // saturating drop count for this cycle's strays
  always_comb begin
    req0     = s0_valid & s0_sof;
    req1     = s1_valid & s1_sof;
    stray0   = s0_valid & ~s0_sof;
    stray1   = s1_valid & ~s1_sof;
    drop_sum = {1'b0, drop_cnt_q} + 17'(stray0) + 17'(stray1);
  end

  // Arbitration FSM: next state, counters and pass-through outputs
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    stall_d       = stall_q;
    drop_cnt_d    = drop_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    err_timeout_d = 1'b0;
    mac_tx_data   = '0;
    mac_tx_valid  = 1'b0;
    mac_tx_sof    = 1'b0;
    mac_tx_eof    = 1'b0;
    s0_ready_c    = 1'b0;
    s1_ready_c    = 1'b0;

    case (state_q)
      IDLE: begin
        stall_d    = '0;
        s0_ready_c = stray0;
        s1_ready_c = stray1;
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (req0 && req1) begin
          state_d = last_grant_q ? BUSY0 : BUSY1;
        end else if (req0) begin
          state_d = BUSY0;
        end else if (req1) begin
          state_d = BUSY1;
        end
      end

      BUSY0, BUSY1: begin
        mac_tx_data  = sel_data;
        mac_tx_valid = sel_valid;
        mac_tx_sof   = sel_sof;
        mac_tx_eof   = sel_eof;
        if (sel_src) begin
          s1_ready_c = mac_tx_ready;
        end else begin
          s0_ready_c = mac_tx_ready;
        end

        if (sel_valid && mac_tx_ready) begin
          stall_d = '0;
          if (sel_eof) begin
            state_d      = IDLE;
            last_grant_d = sel_src;
            frame_cnt_d  = frame_cnt_q + 16'd1;
          end
        end else if (stall_q == STALL_LIMIT) begin
          state_d       = IDLE;
          last_grant_d  = sel_src;
          stall_d       = '0;
          err_timeout_d = 1'b1;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      stall_q       <= '0;
      drop_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      stall_q       <= stall_d;
      drop_cnt_q    <= drop_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Ready must not drain strays while reset is held, even though the
  // idle-state logic would otherwise accept them
  always_comb begin
    s0_ready    = s0_ready_c & rst_n;
    s1_ready    = s1_ready_c & rst_n;
    err_timeout = err_timeout_q;
    drop_cnt    = drop_cnt_q;
    frame_cnt   = frame_cnt_q;
  end

endmodule

// File: tb/tb_mac_tx_arb.sv
// Bench for mac_tx_arb: queue-driven sources, a cycle model of the arbiter
// rules checked on every falling edge, and directed scenarios with literal
// expectations.
module tb_mac_tx_arb;

  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s0_data = '0, s1_data = '0;
  logic          s0_valid = 1'b0, s0_sof = 1'b0, s0_eof = 1'b0, s0_ready;
  logic          s1_valid = 1'b0, s1_sof = 1'b0, s1_eof = 1'b0, s1_ready;
  logic [DW-1:0] mac_tx_data;
  logic          mac_tx_valid, mac_tx_sof, mac_tx_eof;
  logic          mac_tx_ready = 1'b1;
  logic          err_timeout;
  logic [15:0]   drop_cnt, frame_cnt;

  mac_tx_arb #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_sof(s0_sof), .s0_eof(s0_eof), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_sof(s1_sof), .s1_eof(s1_eof), .s1_ready(s1_ready),
    .mac_tx_data(mac_tx_data), .mac_tx_valid(mac_tx_valid), .mac_tx_sof(mac_tx_sof),
    .mac_tx_eof(mac_tx_eof), .mac_tx_ready(mac_tx_ready),
    .err_timeout(err_timeout), .drop_cnt(drop_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sof;
    logic        eof;
    int          gap;
  } word_t;

  typedef struct {
    logic [31:0] data;
    logic        sof;
    logic        eof;
    int          cyc;
  } cap_t;

  word_t q0[$];
  word_t q1[$];
  cap_t  cap[$];

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    err_pulses = 0;
  int    err_cyc = -1;
  int    s1_ready_cnt = 0;
  int    mac_mode = 0;
  logic  acc0 = 1'b0, acc1 = 1'b0;

  // model state: owner -1 means the port is free
  int    m_owner = -1;
  int    m_last = 1;
  int    m_stall = 0;
  int    m_drop = 0;
  int    m_frames = 0;
  logic  m_err = 1'b0;

  logic [31:0] e_data;
  logic        e_valid, e_sof, e_eof, e_r0, e_r1;
  int          n;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  task automatic push(input int src, input logic [31:0] d, input logic sof, input logic eof, input int gap);
    word_t w;
    w.data = d;
    w.sof  = sof;
    w.eof  = eof;
    w.gap  = gap;
    if (src == 0) q0.push_back(w);
    else          q1.push_back(w);
  endtask

  // advance one clock: retire accepted words, present queue heads, drive MAC ready
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    s0_valid = 1'b0; s0_sof = 1'b0; s0_eof = 1'b0;
    s1_valid = 1'b0; s1_sof = 1'b0; s1_eof = 1'b0;
    if (q0.size() > 0) begin
      if (q0[0].gap > 0) q0[0].gap = q0[0].gap - 1;
      else begin
        s0_valid = 1'b1; s0_data = q0[0].data; s0_sof = q0[0].sof; s0_eof = q0[0].eof;
      end
    end
    if (q1.size() > 0) begin
      if (q1[0].gap > 0) q1[0].gap = q1[0].gap - 1;
      else begin
        s1_valid = 1'b1; s1_data = q1[0].data; s1_sof = q1[0].sof; s1_eof = q1[0].eof;
      end
    end
    case (mac_mode)
      1:       mac_tx_ready = ~mac_tx_ready;
      2:       mac_tx_ready = 1'b0;
      default: mac_tx_ready = 1'b1;
    endcase
  endtask

  task automatic runCycles(input int k);
    for (int i = 0; i < k; i++) applyStimulus();
  endtask

  task automatic drainQueues(input string name, input int limit);
    int k;
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0) && k < limit) begin
      applyStimulus();
      k++;
    end
    if (q0.size() > 0 || q1.size() > 0) reportTimeout(name);
    runCycles(4);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    s0_valid = 1'b0; s1_valid = 1'b0;
    mac_mode = 0;
    mac_tx_ready = 1'b1;
    runCycles(2);
    rst_n = 1'b1;
    cap.delete();
    err_pulses = 0;
    err_cyc = -1;
    s1_ready_cnt = 0;
  endtask

  // cycle model of the arbitration rules, compared against the DUT each cycle
  always @(negedge clk) begin
    cyc++;
    acc0 = s0_valid & s0_ready;
    acc1 = s1_valid & s1_ready;
    if (!rst_n) begin
      m_owner = -1; m_last = 1; m_stall = 0; m_drop = 0; m_frames = 0; m_err = 1'b0;
      checkOutput("rst_mac_valid", 32'(mac_tx_valid), 32'd0);
      checkOutput("rst_s0_ready", 32'(s0_ready), 32'd0);
      checkOutput("rst_s1_ready", 32'(s1_ready), 32'd0);
      checkOutput("rst_err", 32'(err_timeout), 32'd0);
      checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
      checkOutput("rst_frames", 32'(frame_cnt), 32'd0);
    end else begin
      e_valid = 1'b0; e_data = '0; e_sof = 1'b0; e_eof = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0;
      if (m_owner < 0) begin
        e_r0 = s0_valid & ~s0_sof;
        e_r1 = s1_valid & ~s1_sof;
      end else if (m_owner == 0) begin
        e_valid = s0_valid; e_data = s0_data; e_sof = s0_sof; e_eof = s0_eof; e_r0 = mac_tx_ready;
      end else begin
        e_valid = s1_valid; e_data = s1_data; e_sof = s1_sof; e_eof = s1_eof; e_r1 = mac_tx_ready;
      end

      checkOutput("mac_valid", 32'(mac_tx_valid), 32'(e_valid));
      checkOutput("s0_ready", 32'(s0_ready), 32'(e_r0));
      checkOutput("s1_ready", 32'(s1_ready), 32'(e_r1));
      checkOutput("err_timeout", 32'(err_timeout), 32'(m_err));
      checkOutput("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      checkOutput("frame_cnt", 32'(frame_cnt), 32'(m_frames));
      if (e_valid) begin
        checkOutput("mac_data", mac_tx_data, e_data);
        checkOutput("mac_sof", 32'(mac_tx_sof), 32'(e_sof));
        checkOutput("mac_eof", 32'(mac_tx_eof), 32'(e_eof));
      end

      m_err = 1'b0;
      if (m_owner < 0) begin
        m_stall = 0;
        m_drop = m_drop + int'(e_r0) + int'(e_r1);
        if (m_drop > 65535) m_drop = 65535;
        if (s0_valid && s0_sof && s1_valid && s1_sof) m_owner = (m_last == 1) ? 0 : 1;
        else if (s0_valid && s0_sof) m_owner = 0;
        else if (s1_valid && s1_sof) m_owner = 1;
      end else if (e_valid && mac_tx_ready) begin
        m_stall = 0;
        if (e_eof) begin
          m_last = m_owner;
          m_owner = -1;
          m_frames = (m_frames + 1) % 65536;
        end
      end else if (m_stall + 1 == TMO - 1) begin
        m_last = m_owner;
        m_owner = -1;
        m_stall = 0;
        m_err = 1'b1;
      end else begin
        m_stall = m_stall + 1;
      end

      if (mac_tx_valid && mac_tx_ready) begin
        cap_t c;
        c.data = mac_tx_data; c.sof = mac_tx_sof; c.eof = mac_tx_eof; c.cyc = cyc;
        cap.push_back(c);
      end
      if (err_timeout) begin
        err_pulses++;
        err_cyc = cyc;
      end
      if (s1_ready) s1_ready_cnt++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // reset values while rst_n is held from time zero
    @(negedge clk);
    checkOutput("init_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("init_mac_valid", 32'(mac_tx_valid), 32'd0);

    // single 4-word frame from s0
    $display("[TB] scenario: 4-word frame from s0");
    doReset();
    for (int i = 0; i < 4; i++) push(0, 32'hCAFE_0000 + 32'(i), i == 0, i == 3, 0);
    runCycles(10);
    checkOutput("t1_words", 32'(cap.size()), 32'd4);
    if (cap.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput("t1_data", cap[i].data, 32'hCAFE_0000 + 32'(i));
        checkOutput("t1_sof", 32'(cap[i].sof), 32'(i == 0));
        checkOutput("t1_eof", 32'(cap[i].eof), 32'(i == 3));
      end
    end
    checkOutput("t1_frames", 32'(frame_cnt), 32'd1);
    checkOutput("t1_s1_ready", 32'(s1_ready_cnt), 32'd0);

    // both sources with three queued 2-word frames each: strict alternation
    $display("[TB] scenario: round-robin with three frames per source");
    doReset();
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 2; w++) begin
        push(0, 32'h100 + 32'(f * 16 + w), w == 0, w == 1, 0);
        push(1, 32'h200 + 32'(f * 16 + w), w == 0, w == 1, 0);
      end
    end
    drainQueues("t2_drain", 100);
    checkOutput("t2_words", 32'(cap.size()), 32'd12);
    if (cap.size() == 12) begin
      for (int k = 0; k < 12; k++) begin
        n = k / 2;
        checkOutput("t2_order", cap[k].data,
                    ((n % 2 == 1) ? 32'h200 : 32'h100) + 32'((n / 2) * 16 + (k % 2)));
      end
      for (int j = 0; j < 5; j++)
        checkOutput("t2_gap", 32'(cap[2 * j + 2].cyc - cap[2 * j + 1].cyc), 32'd2);
    end
    checkOutput("t2_frames", 32'(frame_cnt), 32'd6);

    // strays on s1 while idle
    $display("[TB] scenario: stray words on s1");
    doReset();
    push(1, 32'hDEAD_0001, 1'b0, 1'b0, 0);
    push(1, 32'hDEAD_0002, 1'b0, 1'b0, 0);
    runCycles(6);
    checkOutput("t3_mac_words", 32'(cap.size()), 32'd0);
    checkOutput("t3_drop", 32'(drop_cnt), 32'd2);
    checkOutput("t3_s1_ready", 32'(s1_ready_cnt), 32'd2);

    // s0 stalls after its sof; s1 waits and wins once s0 is aborted
    $display("[TB] scenario: source stall timeout");
    doReset();
    push(0, 32'h5000, 1'b1, 1'b0, 0);
    push(0, 32'h5001, 1'b0, 1'b0, 12);
    push(0, 32'h5002, 1'b0, 1'b1, 0);
    push(1, 32'h6000, 1'b1, 1'b0, 2);
    push(1, 32'h6001, 1'b0, 1'b1, 0);
    drainQueues("t4_drain", 60);
    checkOutput("t4_err_pulses", 32'(err_pulses), 32'd1);
    checkOutput("t4_words", 32'(cap.size()), 32'd3);
    if (cap.size() == 3) begin
      checkOutput("t4_first", cap[0].data, 32'h5000);
      checkOutput("t4_err_delay", 32'(err_cyc - cap[0].cyc), 32'd8);
      checkOutput("t4_s1_word", cap[1].data, 32'h6000);
      checkOutput("t4_s1_grant", 32'(cap[1].cyc - err_cyc), 32'd1);
    end
    checkOutput("t4_drop", 32'(drop_cnt), 32'd2);
    checkOutput("t4_frames", 32'(frame_cnt), 32'd1);

    // MAC ready toggling every cycle through a 5-word frame
    $display("[TB] scenario: toggling mac_tx_ready");
    doReset();
    mac_mode = 1;
    for (int i = 0; i < 5; i++) push(1, 32'h7000 + 32'(i), i == 0, i == 4, 0);
    drainQueues("t5_drain", 40);
    mac_mode = 0;
    checkOutput("t5_words", 32'(cap.size()), 32'd5);
    if (cap.size() == 5)
      for (int i = 0; i < 5; i++) checkOutput("t5_data", cap[i].data, 32'h7000 + 32'(i));
    checkOutput("t5_err", 32'(err_pulses), 32'd0);
    checkOutput("t5_frames", 32'(frame_cnt), 32'd1);

    // MAC ready held low until the first abort, then released
    $display("[TB] scenario: MAC back-pressure timeout");
    doReset();
    mac_mode = 2;
    push(0, 32'h8000, 1'b1, 1'b0, 0);
    push(0, 32'h8001, 1'b0, 1'b1, 0);
    n = 0;
    while (err_pulses == 0 && n < 40) begin
      applyStimulus();
      n++;
    end
    if (err_pulses == 0) reportTimeout("t6_wait_err");
    mac_mode = 0;
    mac_tx_ready = 1'b1;
    runCycles(8);
    checkOutput("t6_err", 32'(err_pulses), 32'd1);
    checkOutput("t6_words", 32'(cap.size()), 32'd2);
    if (cap.size() == 2) checkOutput("t6_first", cap[0].data, 32'h8000);
    checkOutput("t6_frames", 32'(frame_cnt), 32'd1);

    // reset pulse in the middle of an s0 frame
    $display("[TB] scenario: reset mid-frame");
    doReset();
    for (int i = 0; i < 4; i++) push(0, 32'h9000 + 32'(i), i == 0, i == 3, 0);
    n = 0;
    while (cap.size() < 2 && n < 20) begin
      applyStimulus();
      n++;
    end
    if (cap.size() < 2) reportTimeout("t7_wait_words");
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t7_rst_valid", 32'(mac_tx_valid), 32'd0);
    checkOutput("t7_rst_s0_ready", 32'(s0_ready), 32'd0);
    checkOutput("t7_rst_eof", 32'(mac_tx_eof), 32'd0);
    q0.delete();
    applyStimulus();
    rst_n = 1'b1;
    push(1, 32'hB000, 1'b1, 1'b0, 0);
    push(1, 32'hB001, 1'b0, 1'b1, 0);
    drainQueues("t7_drain", 20);
    checkOutput("t7_frames", 32'(frame_cnt), 32'd1);
    checkOutput("t7_words", 32'(cap.size()), 32'd4);
    if (cap.size() == 4) begin
      checkOutput("t7_s1_first", cap[2].data, 32'hB000);
      checkOutput("t7_s1_last", cap[3].data, 32'hB001);
    end

    // single-word frame on s0 while s1 presents a stray in the same cycle
    $display("[TB] scenario: single-word frame with concurrent stray");
    doReset();
    push(0, 32'hC000, 1'b1, 1'b1, 0);
    push(1, 32'hD000, 1'b0, 1'b0, 0);
    runCycles(6);
    checkOutput("t8_words", 32'(cap.size()), 32'd1);
    if (cap.size() == 1) begin
      checkOutput("t8_data", cap[0].data, 32'hC000);
      checkOutput("t8_sof", 32'(cap[0].sof), 32'd1);
      checkOutput("t8_eof", 32'(cap[0].eof), 32'd1);
    end
    checkOutput("t8_drop", 32'(drop_cnt), 32'd1);
    checkOutput("t8_frames", 32'(frame_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_tx_arb.md
MAC_TX_ARB -- requirements
Module: mac_tx_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of every data bus.
REQ-002 SHALL have parameter TIMEOUT, default 1024, stall cycles before a granted frame is aborted (range 2..65535).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 s0_data/s1_data  input  DATA_WIDTH  source frame word.
REQ-006 s0_valid/s1_valid, s0_sof/s1_sof, s0_eof/s1_eof  input  1 each  source word valid, first word, last word.
REQ-007 s0_ready/s1_ready  output  1 each  source word accepted when valid&ready.
REQ-008 mac_tx_data  output  DATA_WIDTH; mac_tx_valid, mac_tx_sof, mac_tx_eof  output  1 each  to MAC TX.
REQ-009 mac_tx_ready  input  1  MAC accepts word when mac_tx_valid&mac_tx_ready.
REQ-010 err_timeout  output  1  one-cycle pulse on frame abort.
REQ-011 drop_cnt  output  16  count of stray words discarded; frame_cnt  output  16  frames completed.

Function
REQ-012 SHALL share the MAC TX port between s0 and s1 at frame granularity; a granted frame is never interleaved with the other source.
REQ-013 FSM states IDLE, BUSY0, BUSY1.
REQ-014 IDLE: source n requests when sn_valid&sn_sof; mac_tx_valid=0, s*_ready=0 for requesting sources.
REQ-015 IDLE, one requester: go BUSYn next cycle; both requesting: grant source other than last_grant (round-robin), last_grant reset value 1 (s0 wins first tie).
REQ-016 IDLE, sn_valid&!sn_sof (stray word): sn_ready=1, word discarded, drop_cnt+1 (saturate at 0xFFFF); applies to both sources same cycle (+2).
REQ-017 BUSYn: mac_tx_data/valid/sof/eof = sn_data/valid/sof/eof combinationally; sn_ready = mac_tx_ready; other source ready=0; zero added latency.
REQ-018 BUSYn: handshake of word with sn_eof=1 -> IDLE next cycle, last_grant<=n, frame_cnt+1 (wraps 0xFFFF->0).
REQ-019 Single-word frame (sof&eof same word) SHALL be granted and completed like any frame: IDLE 1 cycle, BUSY 1 cycle minimum.
REQ-020 BUSYn, word with sof=1 after first handshake: forwarded unchanged (no re-framing); arbiter tracks only eof.
REQ-021 Minimum inter-frame gap at MAC port: 1 cycle (IDLE) between eof handshake and next sof.
REQ-022 Stall counter: cleared on grant and on each handshake; increments each BUSY cycle without handshake; reaching TIMEOUT-1 -> err_timeout=1 for one cycle, state IDLE, last_grant<=n, frame_cnt unchanged.
REQ-023 After abort, remaining words of aborted frame arrive without sof and SHALL be discarded as strays (REQ-016).
REQ-024 Simultaneous request and stray: requesting source granted; stray from other source still drained.
REQ-025 mac_tx_ready held low indefinitely in BUSY SHALL trigger timeout identically to source stall.

Reset
REQ-026 rst_n=0 SHALL immediately force: state IDLE, last_grant=1, stall counter 0, drop_cnt 0, frame_cnt 0, err_timeout 0, mac_tx_valid 0, s0_ready 0, s1_ready 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no eof emitted; first request after release re-arbitrates per REQ-015.
REQ-028 Deassertion is synchronised by the instantiating level; block needs no internal synchroniser.

Verification
REQ-029 s0 sends 4-word frame, mac_tx_ready=1 -> 4 words out unchanged, sof on word1, eof on word4, frame_cnt=1, s1_ready=0 throughout.
REQ-030 s0 and s1 both assert sof same cycle, 3 frames each queued -> output order s0,s1,s0,s1,s0,s1, one idle cycle between frames, frame_cnt=6.
REQ-031 s1 presents 2 words without sof while IDLE -> s1_ready=1 both cycles, nothing on mac_tx, drop_cnt=2.
REQ-032 TIMEOUT=8, s0 sends sof then valid=0 for 8 cycles -> err_timeout pulse 8 cycles after last handshake, state IDLE, pending s1 frame granted next cycle, later s0 words counted in drop_cnt.
REQ-033 mac_tx_ready toggled 1/0 each cycle during 5-word s1 frame -> exactly 5 handshakes, data order preserved, no timeout.
REQ-034 rst_n pulsed low mid-frame of s0 -> all outputs at reset values that cycle; new s1 frame after release completes normally, frame_cnt=1.
